fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the write side of the async FIFO among NREQ producers in the clk_in domain.
//  - Round-robin, burst-limited arbitration; per-requester valid/ready handshake.
//  - Drives the FIFO insert and data_in pins and consumes its full flag.
//  - Sequences FIFO flush requests so a flush never lands mid-beat.
// PARAMETERS
//  NREQ   4   number of requesters (>=2)
//  WIDTH  32  data word width; matches FIFO WIDTH
//  BURST  4   max words accepted per grant before rotating (>=1)
// PORTS
//  clk_in     in   1           sole clock (FIFO write clock)
//  reset      in   1           asynchronous, active-low reset
//  req        in   NREQ        per-requester valid; bit i = requester i
//  req_data   in   NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
//  ready      out  NREQ        per-requester accept; transfer = req[i] & ready[i]
//  flush_req  in   1           level request to flush FIFO
//  full       in   1           FIFO full flag (write-domain view)
//  insert     out  1           FIFO insert strobe
//  data_out   out  WIDTH       to FIFO data_in
//  flush      out  1           FIFO flush, one-cycle pulse
//  gnt_id     out  clog2(NREQ) currently granted requester (valid when busy)
//  busy       out  1           high in GRANT or FLUSH
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, rr_ptr=0, burst_cnt=0, gnt_id=0;
//   ready=0, insert=0, flush=0, busy=0; data_out=0.
//  FSM states: IDLE, GRANT, FLUSH.
//  IDLE:
//   - flush_req=1 -> FLUSH; flush has priority over req.
//   - else any req -> GRANT. gnt_id = first set req bit at or after rr_ptr (wrapping).
//     burst_cnt=0.
//   - ready=0 and insert=0 throughout IDLE.
//  GRANT (g=gnt_id):
//   - ready[g] = ~full & ~flush_req; all other ready bits 0.
//   - insert = req[g] & ready[g], combinational (zero latency).
//   - data_out = req_data[g] (muxed; stable while GRANT).
//   - On transfer: burst_cnt++.
//   - Exit to IDLE and set rr_ptr = (g+1) mod NREQ when either:
//     transfer with burst_cnt==BURST-1, or req[g]==0.
//   - flush_req=1 -> FLUSH; no transfer that cycle; rr_ptr = (g+1) mod NREQ.
//   - full=1 -> hold grant, stall (no insert); the burst count does not advance.
//  FLUSH: flush=1 for exactly one cycle, busy=1; next state IDLE.
//   flush_req still high in IDLE -> another FLUSH (repeats every 2 cycles).
//  Timing: one idle bubble cycle between grants.
//   Max throughput BURST words per BURST+1 cycles.
//  Fairness: a requester with req held waits at most (NREQ-1)*(BURST+1) cycles
//   plus full stalls.
//  Widths: burst_cnt is clog2(BURST) bits, min 1; rr_ptr/gnt_id are clog2(NREQ) bits, min 1.
//  NREQ not a power of 2: rr_ptr wraps at NREQ-1 -> 0.
//  Reset mid-burst: immediate return to IDLE; insert drops asynchronously with reset.
//  insert is never asserted while full=1 or flush=1.
// STRUCTURE
//  Shared header fifo_defs.vh:
//   - state encodings ST_IDLE/ST_GRANT/ST_FLUSH as localparams.
//   - CLOG2 macro or function for width calculation.
//  Sub-module rr_picker #(NREQ): combinational masked priority encoder.
//   - Inputs: req, rr_ptr. Outputs: any, idx.
//  Top holds FSM, burst counter, rr_ptr, data mux.
// TESTING
//  1. Reset -> all outputs 0; release; req=4'b0000 for 10 cycles -> insert stays 0, busy=0.
//  2. req=4'b1111 held, full=0, BURST=4 -> grants 0,1,2,3,0.
//     Each grant gives 4 inserts, then 1 bubble; 16 words in 20 cycles.
//  3. req[2] only, 2 words then drops req -> 2 inserts.
//     IDLE, rr_ptr=3; next req=4'b0101 grants requester 0 (wrap).
//  4. GRANT g=1, full=1 for 5 cycles mid-burst -> ready[1]=0, insert=0, burst_cnt frozen.
//     Burst then completes with remaining words, no loss or duplicate.
//  5. flush_req pulsed 1 cycle mid-burst g=0 after 2 words -> no insert that cycle.
//     Next cycle flush=1 for 1 cycle, then IDLE; next grant goes to requester 1.
//  6. Async reset asserted mid-burst (between clock edges) -> insert/ready/flush go 0 at once.
//     After release, first grant goes to requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_wr_arbiter_pkg;

  // Arbiter FSM state encodings.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Width needed to hold values 0..n-1. Never returns less than 1 bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: returns the first set request bit at or after rr_ptr,
// wrapping at NREQ-1 back to 0. Purely combinational.
module fifo_wr_arbiter_rr_picker
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]                req,
  input  logic [clog2_min1(NREQ)-1:0]    rr_ptr,
  output logic                           any,
  output logic [clog2_min1(NREQ)-1:0]    idx
);

  localparam int IW = clog2_min1(NREQ);

  // Scan requesters starting at rr_ptr; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path through
    // this block leaves a value held over and no latch is inferred.
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[IW'(j)]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO: shares the FIFO insert port among
// NREQ producers with round-robin, burst-limited grants, and sequences flush
// requests so a flush never lands in the middle of a beat.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*WIDTH-1:0]        req_data,
  output logic [NREQ-1:0]              ready,
  input  logic                         flush_req,
  input  logic                         full,
  output logic                         insert,
  output logic [WIDTH-1:0]             data_out,
  output logic                         flush,
  output logic [clog2_min1(NREQ)-1:0]  gnt_id,
  output logic                         busy
);

  localparam int IW = clog2_min1(NREQ);
  localparam int CW = clog2_min1(BURST);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);
  localparam logic [IW-1:0] PTR_LAST   = IW'(NREQ - 1);

  state_e          state;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   burst_cnt;
  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   next_ptr;
  logic            in_grant;

  fifo_wr_arbiter_rr_picker #(.NREQ(NREQ)) u_rr_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  assign in_grant = (state == ST_GRANT);
  // Rotation point after the current grant; explicit wrap handles NREQ that
  // is not a power of two.
  assign next_ptr = (gnt_id == PTR_LAST) ? '0 : gnt_id + 1'b1;

  // Handshake and data path: zero-latency accept for the granted requester.
  always_comb begin
    ready    = '0;
    data_out = '0;
    if (in_grant) begin
      ready[gnt_id] = ~full & ~flush_req;
      for (int i = 0; i < NREQ; i++) begin
        if (IW'(i) == gnt_id) data_out = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // ready is zero outside GRANT and while full/flush_req, so insert can
  // never fire during a stall or a flush.
  assign insert = req[gnt_id] & ready[gnt_id];
  assign flush  = (state == ST_FLUSH);
  assign busy   = (state != ST_IDLE);

  // Arbitration FSM with grant pointer, round-robin pointer and burst count.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      gnt_id    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register in this block
      // updates from pre-edge values, independent of statement order.
      case (state)
        ST_IDLE: begin
          if (flush_req) begin
            state <= ST_FLUSH;
          end else if (pick_any) begin
            state     <= ST_GRANT;
            gnt_id    <= pick_idx;
            burst_cnt <= '0;
          end
        end

        ST_GRANT: begin
          if (flush_req) begin
            state  <= ST_FLUSH;
            rr_ptr <= next_ptr;
          end else if (!req[gnt_id]) begin
            state  <= ST_IDLE;
            rr_ptr <= next_ptr;
          end else if (insert) begin
            if (burst_cnt == BURST_LAST) begin
              state  <= ST_IDLE;
              rr_ptr <= next_ptr;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
          // full: hold grant, counter frozen.
        end

        ST_FLUSH: state <= ST_IDLE;

        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Producers are modelled per
// requester; expected (grant, word) pairs are queued when stimulus is loaded
// and popped as the DUT inserts words into the FIFO.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int BURST = 4;

  logic                    clk_in;
  logic                    reset;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         ready;
  logic                    flush_req;
  logic                    full;
  logic                    insert;
  logic [WIDTH-1:0]        data_out;
  logic                    flush;
  logic [1:0]              gnt_id;
  logic                    busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ready     (ready),
    .flush_req (flush_req),
    .full      (full),
    .insert    (insert),
    .data_out  (data_out),
    .flush     (flush),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]       id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t            sb[$];
  int              ins_cyc[$];
  int              n_cmp;
  int              n_err;
  int              cnt[NREQ];
  int              seq[NREQ];
  int              exp_seq[NREQ];
  logic [NREQ-1:0] xfer;
  int              cycle;
  int              ins_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] word_of(input int i, input int s);
    return {i[7:0], s[23:0]};
  endfunction

  task automatic drive_producers();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (cnt[i] > 0);
      req_data[i*WIDTH +: WIDTH] = word_of(i, seq[i]);
    end
  endtask

  task automatic push_exp(input int id, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = id[1:0];
      e.data = word_of(id, exp_seq[id]);
      sb.push_back(e);
      exp_seq[id]++;
    end
  endtask

  // Observe the DUT mid-cycle; score any insert against the queue.
  task automatic sample();
    exp_t e;
    @(negedge clk_in);
    cycle++;
    xfer = req & ready;
    if (insert) begin
      ins_cnt++;
      ins_cyc.push_back(cycle);
      check("ins_while_full", full, 0);
      check("ins_while_flush", flush, 0);
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_gnt_id", gnt_id, e.id);
        check("sb_data", data_out, e.data);
      end
    end
  endtask

  // Cross the active edge, then retire accepted words in the producers.
  task automatic advance();
    @(posedge clk_in);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer[i]) begin
        seq[i]++;
        cnt[i]--;
      end
    end
    drive_producers();
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic wait_inserts(input string tag, input int target, input int budget);
    int b;
    b = 0;
    while (ins_cnt < target && b < budget) begin
      step();
      b++;
    end
    check(tag, ins_cnt >= target, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int b;

  initial begin
    n_cmp = 0; n_err = 0; cycle = 0; ins_cnt = 0; xfer = '0;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0; seq[i] = 0; exp_seq[i] = 0;
    end
    reset = 1'b0; full = 1'b0; flush_req = 1'b0; req = '0; req_data = '0;

    // 1. Reset state, then quiet idle.
    #3;
    check("rst_insert", insert, 0);
    check("rst_ready", ready, 0);
    check("rst_flush", flush, 0);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 0);
    check("rst_gnt_id", gnt_id, 0);
    repeat (2) @(posedge clk_in);
    #1 reset = 1'b1;
    drive_producers();
    repeat (10) begin
      sample();
      check("idle_insert", insert, 0);
      check("idle_busy", busy, 0);
      advance();
    end

    // 2. All four requesting: grants 0,1,2,3,0, BURST words each, one bubble.
    b = ins_cnt;
    cnt[0] = 8; cnt[1] = 4; cnt[2] = 4; cnt[3] = 4;
    push_exp(0, 4); push_exp(1, 4); push_exp(2, 4); push_exp(3, 4); push_exp(0, 4);
    drive_producers();
    wait_inserts("t2_done", b + 20, 80);
    if (ins_cyc.size() >= b + 20) begin
      check("t2_16_words_span", ins_cyc[b+15] - ins_cyc[b], 18);
      check("t2_bubble", ins_cyc[b+4] - ins_cyc[b+3], 2);
    end
    repeat (3) step();

    // 3. Requester 2 sends two words and drops; pointer wraps to 0 next.
    b = ins_cnt;
    cnt[2] = 2;
    push_exp(2, 2);
    drive_producers();
    wait_inserts("t3_req2", b + 2, 20);
    repeat (3) step();
    sample();
    check("t3_idle_busy", busy, 0);
    advance();
    cnt[0] = 1; cnt[2] = 1;
    push_exp(0, 1); push_exp(2, 1);
    drive_producers();
    wait_inserts("t3_wrap", b + 4, 20);
    repeat (3) step();

    // 4. Grant 1 stalled by full for 5 cycles after 2 words.
    b = ins_cnt;
    cnt[1] = 6;
    push_exp(1, 6);
    drive_producers();
    wait_inserts("t4_first2", b + 2, 20);
    full = 1'b1;
    repeat (5) begin
      sample();
      check("t4_stall_ready", ready, 0);
      check("t4_stall_insert", insert, 0);
      check("t4_stall_gnt", gnt_id, 1);
      advance();
    end
    full = 1'b0;
    wait_inserts("t4_done", b + 6, 30);
    if (ins_cyc.size() >= b + 6) begin
      check("t4_stall_gap", ins_cyc[b+2] - ins_cyc[b+1], 6);
      check("t4_resume_gap", ins_cyc[b+3] - ins_cyc[b+2], 1);
      check("t4_burst_end", ins_cyc[b+4] - ins_cyc[b+3], 2);
    end
    repeat (3) step();

    // 5. Flush request mid-burst on grant 0; next grant goes to requester 1.
    b = ins_cnt;
    cnt[0] = 4; cnt[1] = 1;
    push_exp(0, 2); push_exp(1, 1); push_exp(0, 2);
    drive_producers();
    wait_inserts("t5_first2", b + 2, 20);
    flush_req = 1'b1;
    sample();
    check("t5_req_ready", ready, 0);
    check("t5_req_insert", insert, 0);
    check("t5_req_flush", flush, 0);
    advance();
    flush_req = 1'b0;
    sample();
    check("t5_flush_pulse", flush, 1);
    check("t5_flush_busy", busy, 1);
    check("t5_flush_insert", insert, 0);
    advance();
    sample();
    check("t5_post_flush", flush, 0);
    check("t5_post_busy", busy, 0);
    advance();
    wait_inserts("t5_done", b + 5, 30);
    repeat (3) step();

    // 6. Asynchronous reset in the middle of a burst.
    b = ins_cnt;
    cnt[3] = 4;
    push_exp(3, 4);
    drive_producers();
    wait_inserts("t6_first", b + 1, 20);
    #1;
    check("t6_pre_insert", insert, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_insert", insert, 0);
    check("t6_rst_ready", ready, 0);
    check("t6_rst_flush", flush, 0);
    check("t6_rst_busy", busy, 0);
    sb.delete();
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0;
      exp_seq[i] = seq[i];
    end
    xfer = '0;
    drive_producers();
    repeat (2) @(posedge clk_in);
    #1 reset = 1'b1;
    b = ins_cnt;
    for (int i = 0; i < NREQ; i++) cnt[i] = 1;
    push_exp(0, 1); push_exp(1, 1); push_exp(2, 1); push_exp(3, 1);
    drive_producers();
    wait_inserts("t6_after_rst", b + 4, 40);
    repeat (3) step();

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
